// File: rtl/detector_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : detector_step_sequencer
//  Function : Applies a stored bit pattern, MSB first and one bit per
//             programmable step, to a Mealy and a Moore sequence detector in
//             lockstep. On every step it checks that both machines agree,
//             counts Mealy hits and latches the first disagreement.
//  Options  : SEQ_CTRL_LOOP_EN - when defined, the pattern is replayed
//             continuously; only abort or reset ends a run.
//  Revision : 1.0 - initial release
// ============================================================================
module detector_step_sequencer #(
   parameter int PAT_W = 16,
   parameter int DIV_W = 8
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   start,
   input  logic                   abort,
   input  logic [PAT_W-1:0]       pat_in,
   input  logic [$clog2(PAT_W):0] len_in,
   input  logic [DIV_W-1:0]       interval,
   input  logic                   mealy_z,
   input  logic                   moore_z,
   output logic                   a_out,
   output logic                   step,
   output logic                   busy,
   output logic                   done,
   output logic [$clog2(PAT_W):0] hit_count,
   output logic                   mismatch,
   output logic [$clog2(PAT_W):0] mismatch_step
);

   localparam int CNT_W = $clog2(PAT_W) + 1;
   localparam logic [CNT_W-1:0] C_LEN_MAX = CNT_W'(PAT_W);
   localparam logic [CNT_W-1:0] C_HIT_MAX = '1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_STEP  = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic [PAT_W-1:0] r_pat;         // working copy, current bit in the MSB
   logic [CNT_W-1:0] r_len;         // clamped number of bits to apply
   logic [CNT_W-1:0] r_idx;         // steps already checked this pass
   logic [DIV_W-1:0] r_interval;    // captured so the run is immune to input changes
   logic [DIV_W-1:0] r_cnt;         // idle cycles left before the next step
   logic             r_mealy_s;     // Mealy Z sampled before the detectors advance

`ifdef SEQ_CTRL_LOOP_EN
   logic [PAT_W-1:0] r_pat_cap;     // original pattern, reloaded on every pass
   logic             r_loop_done;   // end-of-pass pulse while the run continues
`endif

   logic [CNT_W-1:0] w_len_clamped;
   logic [CNT_W-1:0] w_idx_inc;
   logic             w_last;

   assign w_len_clamped = (len_in > C_LEN_MAX) ? C_LEN_MAX : len_in;
   assign w_idx_inc     = r_idx + CNT_W'(1);
   assign w_last        = (w_idx_inc == r_len);

   // State register; reset forces IDLE so step/busy/a_out drop at once
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode; start has priority over abort in IDLE
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_next = (w_len_clamped == '0) ? ST_DONE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (abort) begin
               w_state_next = ST_IDLE;
            end else if (r_cnt == '0) begin
               w_state_next = ST_STEP;
            end
         end
         ST_STEP: begin
            // the step pulse is already out; an abort only skips the check
            w_state_next = abort ? ST_IDLE : ST_CHECK;
         end
         ST_CHECK: begin
            if (abort) begin
               w_state_next = ST_IDLE;
            end else if (w_last) begin
`ifdef SEQ_CTRL_LOOP_EN
               w_state_next = ST_WAIT;
`else
               w_state_next = ST_DONE;
`endif
            end else begin
               w_state_next = ST_WAIT;
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Datapath: capture on start, count down in WAIT, sample in STEP, score in CHECK
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_pat         <= '0;
         r_len         <= '0;
         r_idx         <= '0;
         r_interval    <= '0;
         r_cnt         <= '0;
         r_mealy_s     <= 1'b0;
         hit_count     <= '0;
         mismatch      <= 1'b0;
         mismatch_step <= '0;
`ifdef SEQ_CTRL_LOOP_EN
         r_pat_cap     <= '0;
         r_loop_done   <= 1'b0;
`endif
      end else begin
`ifdef SEQ_CTRL_LOOP_EN
         r_loop_done <= 1'b0;
`endif
         unique case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_pat         <= pat_in;
                  r_len         <= w_len_clamped;
                  r_idx         <= '0;
                  r_interval    <= interval;
                  r_cnt         <= interval;
                  hit_count     <= '0;
                  mismatch      <= 1'b0;
                  mismatch_step <= '0;
`ifdef SEQ_CTRL_LOOP_EN
                  r_pat_cap     <= pat_in;
`endif
               end
            end
            ST_WAIT: begin
               if (!abort && (r_cnt != '0)) begin
                  r_cnt <= r_cnt - DIV_W'(1);
               end
            end
            ST_STEP: begin
               r_mealy_s <= mealy_z;
            end
            ST_CHECK: begin
               if (!abort) begin
                  // moore_z now shows the post-edge result of the same bit
                  if (r_mealy_s && (hit_count != C_HIT_MAX)) begin
                     hit_count <= hit_count + CNT_W'(1);
                  end
                  if ((r_mealy_s != moore_z) && !mismatch) begin
                     mismatch      <= 1'b1;
                     mismatch_step <= w_idx_inc;
                  end
                  r_cnt <= r_interval;
`ifdef SEQ_CTRL_LOOP_EN
                  if (w_last) begin
                     r_pat       <= r_pat_cap;
                     r_idx       <= '0;
                     r_loop_done <= 1'b1;
                  end else begin
                     r_pat <= r_pat << 1;
                     r_idx <= w_idx_inc;
                  end
`else
                  r_pat <= r_pat << 1;
                  r_idx <= w_idx_inc;
`endif
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy  = (r_state == ST_WAIT) || (r_state == ST_STEP) || (r_state == ST_CHECK);
   assign step  = (r_state == ST_STEP);
   // the MSB only changes on the CHECK edge, so A is steady around each step
   assign a_out = busy && r_pat[PAT_W-1];
`ifdef SEQ_CTRL_LOOP_EN
   assign done  = (r_state == ST_DONE) || r_loop_done;
`else
   assign done  = (r_state == ST_DONE);
`endif

endmodule
`default_nettype wire
